// File: rtl/fifo_param_if.sv
// Producer/consumer bundle for fifo_param: write port, read port, flush and status.
// The master modport belongs to the user of the FIFO; the FIFO itself takes the slave modport.
interface fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              clear;
    logic [DATA_W-1:0] data_in;
    logic              write_en;
    logic [DATA_W-1:0] data_out;
    logic              read_en;
    logic              read_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear, data_in, write_en, read_en,
        input  data_out, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, data_in, write_en, read_en,
        output data_out, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO; registered read (1-cycle) or FWFT (0-cycle), registered flags/count.
// Backpressure: writes when full and reads when empty are dropped and latched in sticky error flags.
module fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 2**ADDR_W - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_param_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            af_q, af_d;
    logic            ae_q, ae_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            wr_acc, rd_acc;

    // Flush wins over any same-cycle request, so nothing is accepted while clear is high.
    assign wr_acc = bus.write_en & ~full_q  & ~bus.clear;
    assign rd_acc = bus.read_en  & ~empty_q & ~bus.clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (bus.write_en & full_q);
            udf_d = udf_q | (bus.read_en & empty_q);
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out   = mem_q[rd_ptr_q[ADDR_W-1:0]];
            assign bus.read_valid = ~empty_q;
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q;
            logic              rvalid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q   <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) dout_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                end
            end

            assign bus.data_out   = dout_q;
            assign bus.read_valid = rvalid_q;
        end
    endgenerate

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised successor to the team's 8-bit/256-entry sync FIFO. Single clock domain. Configurable data width and depth, and selectable read mode (registered or first-word-fall-through). Adds fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. True simultaneous read+write is supported. Sits between producer/consumer datapath stages and serves as the drop-in buffer for new designs.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 8, address width; DEPTH = 2**ADDR_W entries (ADDR_W>=1)
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
AF_LEVEL, 2**ADDR_W-4, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush, active high
data_in  input  DATA_W  write data
write_en  input  1  write request
data_out  output  DATA_W  read data
read_en  input  1  read request (mode 0) / pop acknowledge (FWFT)
read_valid  output  1  data_out valid
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_W+1  words stored (0..DEPTH)
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, async): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, read_valid=0, data_out=0 (mode 0), overflow=underflow=0. Memory contents are not reset.
- Pointers are ADDR_W+1 bits. The MSB is the wrap bit. Pointers wrap modulo 2*DEPTH.
- Flags and count are registered and consistent with each other. All are derived from the post-edge state.
- Acceptance: wr_acc = write_en & !full; rd_acc = read_en & !empty. Both use the current-cycle flags. Both can be accepted in the same cycle.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Full + write_en + read_en: read accepted, write rejected, overflow set, count becomes DEPTH-1.
- Empty + write_en + read_en: write accepted, read rejected, underflow set. No bypass: data_out/read_valid are unaffected that cycle.
- Mode 0: on rd_acc at edge N, data_out = mem[rd_ptr] and read_valid=1 after edge N. read_valid is a one-cycle pulse per accepted read. data_out holds its value otherwise.
- FWFT mode: data_out = mem[rd_ptr] combinationally and read_valid = !empty. A word written at edge N is visible after edge N. read_en with read_valid=1 pops the word at the next edge. data_out is don't-care when read_valid=0.
- Memory write: mem[wr_ptr[ADDR_W-1:0]] <= data_in on wr_acc.
- overflow/underflow: set on a rejected write/read request. They hold until clear or reset.
- clear: at the next edge, pointers, count and sticky flags return to their reset values and read_valid=0. clear overrides same-cycle write_en/read_en (neither is accepted). data_out holds its value.
- Reset mid-operation aborts immediately. No partial write survives into the pointer state.

Test Plan:
- Reset, then 1 write of 0xA5 -> count=1, empty=0; mode 0 read -> read_valid pulses 1 cycle with data_out=0xA5, empty=1.
- Fill DEPTH=16 (ADDR_W=4) with 0..15 -> full=1 at count=16, almost_full from count 12. A 17th write sets overflow and count stays 16. Drain -> data 0..15 in order. A further read sets underflow.
- Hold full, assert write_en+read_en -> read returns 0, write dropped, count=15. Then both again at count=15 -> both accepted, count stays 15.
- Run 3*DEPTH continuous simultaneous write/read with an incrementing pattern -> wrap-around is correct, no data loss or duplication, flags are stable.
- FWFT=1: write 0x3C -> read_valid=1 and data_out=0x3C the next cycle without read_en. Assert read_en -> empty=1 after the edge.
- With count=5 and overflow=1, assert clear together with write_en -> count=0, empty=1, overflow=0, nothing written. Then assert rst_n low mid-burst -> all outputs return to reset values immediately.
